dem_tree_scheduler: RTL and testbench

//  Time-multiplexes one shared SwitchingBlock (WIDTH-bit, registered outputs) over a binary DEM tree.

---
 rtl/dem_tree_scheduler_pkg.sv | 25 ++
 rtl/dem_tree_scheduler_lfsr.sv | 38 +++
 rtl/dem_tree_scheduler.sv | 174 +++++++++++++++++
 tb/tb_dem_tree_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dem_tree_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// dem_pkg
// Shared types and constants for the DEM tree scheduler.
//   dem_state_e : scheduler FSM states
//   LFSR_W      : PN generator width
//   LFSR_TAPS   : feedback taps of x^15 + x^14 + 1 (bits 14 and 13)
//   nodes()     : number of switch operations for a tree of a given depth
// ---------------------------------------------------------------------------
package dem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } dem_state_e;

    localparam int                LFSR_W    = 15;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;

    function automatic int nodes(input int levels);
        return (1 << levels) - 1;
    endfunction

endpackage

// File: rtl/dem_tree_scheduler_lfsr.sv
// ---------------------------------------------------------------------------
// dem_lfsr
// 15-bit Fibonacci LFSR supplying the per-node PN bit. Shifts left with the
// feedback entering bit 0; advances only when adv_i is high.
// Ports:
//   clk_i   in  clock
//   reset_i in  synchronous active-high reset, reloads SEED
//   adv_i   in  advance one step at the next edge
//   bit_o   out current PN bit (bit 0 of the register)
// ---------------------------------------------------------------------------
module dem_lfsr
    import dem_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 15'h4A5D
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic adv_i,
    output logic bit_o
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_fb;

    assign w_fb  = ^(r_lfsr & LFSR_TAPS);
    assign bit_o = r_lfsr[0];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_lfsr <= SEED;
        end else if (adv_i) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/dem_tree_scheduler.sv
// ---------------------------------------------------------------------------
// dem_tree_scheduler
// Time-multiplexes one external SwitchingBlock (registered outputs) over a
// binary DEM tree. One quantized sample is accepted, its 2^LEVELS-1 nodes are
// split breadth-first (ISSUE drives the block, CAPTURE stores both halves),
// and the 2^LEVELS leaves become unit-element enables.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   sample_valid_i/ready_o  sample handshake (no skid buffer)
//   sample_i                quantized sample, saturated to ELEMS
//   sw_x_o, sw_pn_o         node value and PN bit to the SwitchingBlock
//   sw_out1_i, sw_out2_i    split halves from the SwitchingBlock
//   elem_o, elem_valid_o    unit-element enables and their update strobe
//   busy_o                  tree walk in progress
//   sum_err_o               sticky split-sum error
// Optional feature: define DEM_SUMCHECK_EN to build the split-sum checker;
// otherwise sum_err_o is tied low.
// ---------------------------------------------------------------------------
module dem_tree_scheduler
    import dem_pkg::*;
#(
    parameter int                WIDTH     = 5,
    parameter int                LEVELS    = 3,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 15'h4A5D
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         sample_valid_i,
    output logic                         sample_ready_o,
    input  logic [WIDTH-1:0]             sample_i,
    output logic [WIDTH-1:0]             sw_x_o,
    output logic                         sw_pn_o,
    input  logic [WIDTH-1:0]             sw_out1_i,
    input  logic [WIDTH-1:0]             sw_out2_i,
    output logic [(1 << LEVELS)-1:0]     elem_o,
    output logic                         elem_valid_o,
    output logic                         busy_o,
    output logic                         sum_err_o
);

    localparam int               NODES   = nodes(LEVELS);
    localparam int               ELEMS   = NODES + 1;
    localparam int               K_W     = $clog2(NODES);
    localparam int               IDX_W   = K_W + 1;
    localparam logic [WIDTH-1:0] ELEMS_V = WIDTH'(ELEMS);
    localparam logic [K_W-1:0]   K_LAST  = K_W'(NODES - 1);

    dem_state_e         r_state;
    dem_state_e         w_next;
    logic [K_W-1:0]     r_k;
    logic [WIDTH-1:0]   r_node [0:2*NODES];
    logic [ELEMS-1:0]   r_elem;
    logic [ELEMS-1:0]   w_elem;
    logic               w_accept;
    logic               w_last;
    logic               w_pn;
    logic [WIDTH-1:0]   w_cur;
    logic [WIDTH-1:0]   w_clamped;
    logic [IDX_W-1:0]   w_idx1;
    logic [IDX_W-1:0]   w_idx2;

    assign w_accept  = sample_ready_o && sample_valid_i;
    assign w_last    = (r_k == K_LAST);
    assign w_cur     = r_node[{1'b0, r_k}];
    assign w_clamped = (sample_i > ELEMS_V) ? ELEMS_V : sample_i;
    // Children of node k live at 2k+1 and 2k+2.
    assign w_idx1    = {r_k, 1'b1};
    assign w_idx2    = w_idx1 + IDX_W'(1);

    // Leaves occupy the buffer tail; a leaf is active when non-zero.
    for (genvar j = 0; j < ELEMS; j++) begin : g_leaf
        assign w_elem[j] = |r_node[NODES+j];
    end

    dem_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .adv_i   (r_state == ISSUE),
        .bit_o   (w_pn)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ISSUE;
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = w_last ? DONE : ISSUE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        sample_ready_o = (r_state == IDLE) && !reset_i;
        busy_o         = (r_state != IDLE);
        sw_x_o         = '0;
        sw_pn_o        = 1'b0;
        elem_valid_o   = (r_state == DONE);
        elem_o         = r_elem;
        if (r_state == ISSUE) begin
            sw_x_o  = w_cur;
            sw_pn_o = w_pn;
        end
        // The new pattern is visible during the strobe cycle itself.
        if (r_state == DONE) begin
            elem_o = w_elem;
        end
    end

    // ---------------- Datapath ----------------
    // NOTE: the node buffer is reset explicitly so a walk after reset is
    // bit-identical to one after power-on.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_k    <= '0;
            r_elem <= '0;
            for (int i = 0; i <= 2*NODES; i++) begin
                r_node[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_node[0] <= w_clamped;
                        r_k       <= '0;
                    end
                end
                CAPTURE: begin
                    r_node[w_idx1] <= sw_out1_i;
                    r_node[w_idx2] <= sw_out2_i;
                    if (!w_last) begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                DONE:    r_elem <= w_elem;
                default: ;
            endcase
        end
    end

`ifdef DEM_SUMCHECK_EN
    // A correct split conserves the node value; the sum is one bit wider.
    logic [WIDTH:0] w_sum;
    logic           r_sum_err;

    assign w_sum = {1'b0, sw_out1_i} + {1'b0, sw_out2_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sum_err <= 1'b0;
        end else if (r_state == CAPTURE && w_sum != {1'b0, w_cur}) begin
            r_sum_err <= 1'b1;
        end
    end

    assign sum_err_o = r_sum_err;
`else
    assign sum_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dem_tree_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dem_tree_scheduler
// Drives dem_tree_scheduler (WIDTH=5, LEVELS=3) with a behavioural
// SwitchingBlock in the loop. A tree-level reference model (plain arithmetic
// on an array of node values plus the PN recurrence) predicts every issued
// node value, PN bit and final unit-element pattern.
// ---------------------------------------------------------------------------
module tb_dem_tree_scheduler;

    localparam int          WIDTH  = 5;
    localparam int          LEVELS = 3;
    localparam int          NODES  = 7;
    localparam int          ELEMS  = 8;
    localparam logic [14:0] SEED   = 15'h4A5D;
`ifdef DEM_SUMCHECK_EN
    localparam bit SUMCHK = 1'b1;
`else
    localparam bit SUMCHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             valid = 1'b0;
    logic             ready;
    logic [WIDTH-1:0] sample = '0;
    logic [WIDTH-1:0] sw_x;
    logic             sw_pn;
    logic [WIDTH-1:0] sw_out1 = '0;
    logic [WIDTH-1:0] sw_out2 = '0;
    logic [ELEMS-1:0] elem;
    logic             elem_valid;
    logic             busy;
    logic             sum_err;

    always #5 clk = ~clk;

    dem_tree_scheduler #(
        .WIDTH     (WIDTH),
        .LEVELS    (LEVELS),
        .LFSR_SEED (SEED)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .sample_valid_i (valid),
        .sample_ready_o (ready),
        .sample_i       (sample),
        .sw_x_o         (sw_x),
        .sw_pn_o        (sw_pn),
        .sw_out1_i      (sw_out1),
        .sw_out2_i      (sw_out2),
        .elem_o         (elem),
        .elem_valid_o   (elem_valid),
        .busy_o         (busy),
        .sum_err_o      (sum_err)
    );

    // SwitchingBlock stand-in: registered halves; the odd unit goes to
    // out1 when pn=1, to out2 when pn=0. corrupt_now adds one to out1.
    logic corrupt_now = 1'b0;
    always @(posedge clk) begin
        sw_out1 <= (sw_x >> 1) + {{(WIDTH-1){1'b0}}, sw_x[0] & sw_pn}
                               + {{(WIDTH-1){1'b0}}, corrupt_now};
        sw_out2 <= (sw_x >> 1) + {{(WIDTH-1){1'b0}}, sw_x[0] & ~sw_pn};
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [14:0]      m_lfsr;
    int               exp_x  [0:NODES-1];
    bit               exp_pn [0:NODES-1];
    logic [ELEMS-1:0] exp_elem;
    int               exp_cnt;
    logic [ELEMS-1:0] last_elem;
    bit               elem_known;
    bit               exp_err;

    function automatic void model_walk(input int s);
        int val [0:2*NODES];
        int h;
        int odd;
        val[0]  = (s > ELEMS) ? ELEMS : s;
        exp_cnt = val[0];
        for (int n = 0; n < NODES; n++) begin
            exp_pn[n] = m_lfsr[0];
            m_lfsr    = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
            exp_x[n]  = val[n];
            h         = val[n] / 2;
            odd       = val[n] % 2;
            val[2*n+1] = h + ((odd == 1 && exp_pn[n]) ? 1 : 0);
            val[2*n+2] = h + ((odd == 1 && !exp_pn[n]) ? 1 : 0);
        end
        for (int j = 0; j < ELEMS; j++) begin
            exp_elem[j] = (val[NODES+j] != 0);
        end
    endfunction

    // Called at a falling edge; holds reset for n rising edges.
    task automatic do_reset(input int n);
        reset = 1'b1;
        valid = 1'b0;
        #1;
        check("ready_in_reset", ready, 0);
        repeat (n) begin
            @(negedge clk);
            check("no_strobe_in_reset", elem_valid, 0);
        end
        reset      = 1'b0;
        m_lfsr     = SEED;
        exp_err    = 1'b0;
        last_elem  = '0;
        elem_known = 1'b1;
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_elem", elem, 0);
        check("rst_strobe", elem_valid, 0);
        check("rst_sw_x", sw_x, 0);
        check("rst_sw_pn", sw_pn, 0);
        check("rst_sum_err", sum_err, 0);
    endtask

    // One full walk, entered and left at a falling edge. hold keeps valid
    // high afterwards; chk enables value checks; corrupt breaks node 2.
    task automatic run(input int v, input bit hold, input bit chk, input bit corrupt);
        int waited;
        waited = 0;
        sample = WIDTH'(v);
        valid  = 1'b1;
        while (!ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_accept", ready, 1);
        if (!ready) return;
        model_walk(v);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) valid = 1'b0;
            corrupt_now = corrupt && (c == 5);
            if (c == 7 && corrupt && SUMCHK) exp_err = 1'b1;
            check("sum_err", sum_err, exp_err);
            if (c <= 15) begin
                check("busy", busy, 1);
                check("ready_busy", ready, 0);
                check("strobe", elem_valid, c == 15);
                if (c % 2 == 1) begin
                    check("pn", sw_pn, exp_pn[(c-1)/2]);
                    if (chk) check("node_x", sw_x, exp_x[(c-1)/2]);
                end else begin
                    check("idle_x", sw_x, 0);
                    check("idle_pn", sw_pn, 0);
                end
                if (c < 15 && elem_known) check("elem_hold", elem, last_elem);
                if (c == 15) begin
                    elem_known = chk;
                    if (chk) begin
                        check("elem", elem, exp_elem);
                        check("popcount", $countones(elem), exp_cnt);
                        last_elem = exp_elem;
                    end
                end
            end else begin
                check("ready_back", ready, 1);
                check("busy_end", busy, 0);
                check("strobe_end", elem_valid, 0);
                if (elem_known) check("elem_after", elem, last_elem);
            end
        end
    endtask

    initial begin
        m_lfsr     = SEED;
        exp_err    = 1'b0;
        elem_known = 1'b1;
        last_elem  = '0;
        @(negedge clk);
        do_reset(2);

        // Case 1: single sample, full latency and handshake timing.
        run(5, 0, 1, 0);
        // Case 2: extremes.
        run(0, 0, 1, 0);
        check("zero_pattern", elem, 8'h00);
        run(8, 0, 1, 0);
        check("full_pattern", elem, 8'hFF);
        // Case 3: saturation.
        run(20, 0, 1, 0);
        check("clamp_pattern", elem, 8'hFF);
        // Case 4: valid held across back-to-back samples.
        run(3, 1, 1, 0);
        run(6, 1, 1, 0);
        run(1, 0, 1, 0);

        // Randomized samples with random idle gaps.
        for (int i = 0; i < 24; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("idle_ready", ready, 1);
                check("idle_elem", elem, last_elem);
                check("idle_strobe", elem_valid, 0);
            end
            run($urandom_range(0, 31), 0, 1, 0);
        end

        // Case 5: reset in the middle of a walk.
        run(7, 0, 1, 0);
        sample = 5'd5;
        valid  = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check("pre_abort_busy", busy, 1);
            check("pre_abort_strobe", elem_valid, 0);
            @(negedge clk);
        end
        do_reset(2);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check("abort_no_strobe", elem_valid, 0);
            check("abort_elem", elem, 0);
        end
        run(5, 0, 1, 0);

        // Case 6: a broken split at node 2.
        run(7, 0, 0, 1);
        run(6, 0, 1, 0);
        check("sum_err_sticky", sum_err, SUMCHK);
        @(negedge clk);
        do_reset(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
